// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//
// Writeback-stage arbiter for the register file write port. Two result
// sources are merged:
//   * the in-order main pipeline (MEM stage), which always has priority;
//   * a long-latency unit (mul/div, slow load), whose results arrive on a
//     valid/ready handshake and wait in a small FIFO until the main source
//     is idle.
// The winner of each cycle is registered onto the W outputs (1-cycle
// latency). A pending-write mask built from the queued entries is exported
// for the hazard unit. If the FIFO head waits too long, hold_req asks the
// hazard unit to freeze main-pipeline writes.
//
// Optional feature macro: WB_BYPASS_EN
//   Defined   : a long-latency result arriving while the FIFO is empty and
//               the main source is idle goes straight to the W registers.
//   Undefined : every long-latency result passes through the FIFO.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   regwriteM, rdM,       main-pipeline write request
//   resultM
//   lu_valid, lu_ready,   long-latency result handshake
//   lu_rd, lu_data
//   regwriteW, rdW,       registered register file write port
//   resultW
//   pend_mask             bit r set while any queued entry targets r
//   fifo_count            number of queued entries
//   hold_req              registered starvation hold request
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int WAD          = 5,
    parameter int WD           = 32,
    parameter int DEPTH        = 4,
    parameter int STARVE_LIMIT = 8
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         regwriteM,
    input  logic [WAD-1:0]               rdM,
    input  logic [WD-1:0]                resultM,
    input  logic                         lu_valid,
    output logic                         lu_ready,
    input  logic [WAD-1:0]               lu_rd,
    input  logic [WD-1:0]                lu_data,
    output logic                         regwriteW,
    output logic [WAD-1:0]               rdW,
    output logic [WD-1:0]                resultW,
    output logic [(2**WAD)-1:0]          pend_mask,
    output logic [$clog2(DEPTH+1)-1:0]   fifo_count,
    output logic                         hold_req
);

    localparam int NREG = 2**WAD;
    localparam int PW   = $clog2(DEPTH);
    localparam int CW   = $clog2(DEPTH+1);
    localparam int SW   = $clog2(STARVE_LIMIT+1);

    // FIFO storage and state
    logic [WAD-1:0] rd_mem   [DEPTH];
    logic [WD-1:0]  data_mem [DEPTH];
    logic           valid_reg [DEPTH];
    logic [PW-1:0]  wr_ptr_reg;
    logic [PW-1:0]  rd_ptr_reg;
    logic [CW-1:0]  count_reg;
    logic [CW-1:0]  count_next;

    // Starvation tracking
    logic [SW-1:0]  starve_reg;
    logic [SW-1:0]  starve_next;
    logic           popped_reg;
    logic           hold_reg;

    // Registered write port
    logic           regwrite_reg;
    logic [WAD-1:0] rd_reg;
    logic [WD-1:0]  result_reg;

    // Arbitration terms
    logic           main_win;
    logic           fifo_empty;
    logic           fifo_full;
    logic           accept;
    logic           bypass;
    logic           push;
    logic           pop;
    logic [WAD-1:0] head_rd;
    logic [WD-1:0]  head_data;

    // A main write to register 0 is treated as idle so the FIFO can drain.
    assign main_win   = regwriteM && (rdM != '0);
    assign fifo_empty = (count_reg == '0);
    // Fullness is judged on the registered count only: a same-cycle pop
    // does not open a slot for a same-cycle push.
    assign fifo_full  = (count_reg == CW'(DEPTH));
    assign lu_ready   = !rst && !fifo_full;
    assign accept     = lu_valid && lu_ready;

`ifdef WB_BYPASS_EN
    assign bypass = accept && fifo_empty && !main_win;
`else
    assign bypass = 1'b0;
`endif

    assign push = accept && !bypass;
    // An entry pushed into an empty FIFO is not visible until the next
    // cycle because fifo_empty comes from the registered count.
    assign pop  = !main_win && !fifo_empty;

    assign head_rd   = rd_mem[rd_ptr_reg];
    assign head_data = data_mem[rd_ptr_reg];

    // Per-entry storage, valid flags and pending-register decode
    logic [NREG-1:0] entry_mask [DEPTH];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            always_ff @(posedge clk) begin
                if (push && (wr_ptr_reg == PW'(gi))) begin
                    rd_mem[gi]   <= lu_rd;
                    data_mem[gi] <= lu_data;
                end
            end

            // Push and pop never hit the same slot: that would need the
            // FIFO to be both full (for the pop) and not full (for the push).
            always_ff @(posedge clk) begin
                if (rst) begin
                    valid_reg[gi] <= 1'b0;
                end else if (push && (wr_ptr_reg == PW'(gi))) begin
                    valid_reg[gi] <= 1'b1;
                end else if (pop && (rd_ptr_reg == PW'(gi))) begin
                    valid_reg[gi] <= 1'b0;
                end
            end

            assign entry_mask[gi] = valid_reg[gi] ? (NREG'(1) << rd_mem[gi]) : '0;
        end
    endgenerate

    always_comb begin
        pend_mask = '0;
        for (int e = 0; e < DEPTH; e++) begin
            pend_mask = pend_mask | entry_mask[e];
        end
    end

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Counter saturates at the limit so hold_req stays asserted until the
    // head is finally drained.
    always_comb begin
        starve_next = starve_reg;
        if (fifo_empty || pop) begin
            starve_next = '0;
        end else if (starve_reg != SW'(STARVE_LIMIT)) begin
            starve_next = starve_reg + SW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            starve_reg <= '0;
            popped_reg <= 1'b0;
            hold_reg   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PW'(1);
            end
            if (pop) begin
                rd_ptr_reg <= rd_ptr_reg + PW'(1);
            end
            count_reg  <= count_next;
            starve_reg <= starve_next;
            popped_reg <= pop;
            // Release happens one edge after the draining pop.
            if (starve_reg == SW'(STARVE_LIMIT)) begin
                hold_reg <= 1'b1;
            end else if (popped_reg) begin
                hold_reg <= 1'b0;
            end
        end
    end

    // Write port: main first, then FIFO head, then (optionally) bypass.
    // When nothing is written the address and data hold their last values.
    always_ff @(posedge clk) begin
        if (rst) begin
            regwrite_reg <= 1'b0;
            rd_reg       <= '0;
            result_reg   <= '0;
        end else if (main_win) begin
            regwrite_reg <= 1'b1;
            rd_reg       <= rdM;
            result_reg   <= resultM;
        end else if (pop) begin
            // A queued write to register 0 is consumed without a write.
            regwrite_reg <= (head_rd != '0);
            if (head_rd != '0) begin
                rd_reg     <= head_rd;
                result_reg <= head_data;
            end
        end else if (bypass) begin
            regwrite_reg <= (lu_rd != '0);
            if (lu_rd != '0) begin
                rd_reg     <= lu_rd;
                result_reg <= lu_data;
            end
        end else begin
            regwrite_reg <= 1'b0;
        end
    end

    assign regwriteW  = regwrite_reg;
    assign rdW        = rd_reg;
    assign resultW    = result_reg;
    assign fifo_count = count_reg;
    assign hold_req   = hold_reg;

endmodule

// File: tb/tb_wb_arbiter.sv
// ---------------------------------------------------------------------------
// tb_wb_arbiter
//
// Directed testbench for wb_arbiter with default parameters (WAD=5, WD=32,
// DEPTH=4, STARVE_LIMIT=8). Each scenario task drives stimulus and checks
// hand-computed expectations. Inputs change 1 time unit after a rising edge
// and outputs are sampled at that same point.
// ---------------------------------------------------------------------------
module tb_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        regwriteM;
    logic [4:0]  rdM;
    logic [31:0] resultM;
    logic        lu_valid;
    logic        lu_ready;
    logic [4:0]  lu_rd;
    logic [31:0] lu_data;
    logic        regwriteW;
    logic [4:0]  rdW;
    logic [31:0] resultW;
    logic [31:0] pend_mask;
    logic [2:0]  fifo_count;
    logic        hold_req;

    int n_checks = 0;
    int n_fail   = 0;

    wb_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .regwriteM  (regwriteM),
        .rdM        (rdM),
        .resultM    (resultM),
        .lu_valid   (lu_valid),
        .lu_ready   (lu_ready),
        .lu_rd      (lu_rd),
        .lu_data    (lu_data),
        .regwriteW  (regwriteW),
        .rdW        (rdW),
        .resultW    (resultW),
        .pend_mask  (pend_mask),
        .fifo_count (fifo_count),
        .hold_req   (hold_req)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; lu_valid = 1'b1; lu_rd = 5'd3; lu_data = 32'h33;
        regwriteM = 1'b0; rdM = '0; resultM = '0;
        step();
        step();
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL reset_lu_ready: got %b, want 0", lu_ready); end
        n_checks++; if (regwriteW !== 1'b0) begin n_fail++; $display("FAIL reset_regwriteW: got %b, want 0", regwriteW); end
        n_checks++; if (rdW !== 5'd0) begin n_fail++; $display("FAIL reset_rdW: got %0d, want 0", rdW); end
        n_checks++; if (resultW !== 32'h0) begin n_fail++; $display("FAIL reset_resultW: got %h, want 0", resultW); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d, want 0", fifo_count); end
        n_checks++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL reset_pend: got %h, want 0", pend_mask); end
        n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b, want 0", hold_req); end
        rst = 1'b0; lu_valid = 1'b0;
        #0;
        n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL reset_release_ready: got %b, want 1", lu_ready); end
        $display("test_reset done");
    endtask

    task automatic test_main_only();
        regwriteM = 1'b1; rdM = 5'd5; resultM = 32'hDEADBEEF;
        step();
        n_checks++; if (regwriteW !== 1'b1) begin n_fail++; $display("FAIL main_we: got %b, want 1", regwriteW); end
        n_checks++; if (rdW !== 5'd5) begin n_fail++; $display("FAIL main_rd: got %0d, want 5", rdW); end
        n_checks++; if (resultW !== 32'hDEADBEEF) begin n_fail++; $display("FAIL main_data: got %h, want deadbeef", resultW); end
        rdM = 5'd0; resultM = 32'h12345678;
        step();
        n_checks++; if (regwriteW !== 1'b0) begin n_fail++; $display("FAIL main_r0_we: got %b, want 0", regwriteW); end
        n_checks++; if (rdW !== 5'd5) begin n_fail++; $display("FAIL main_idle_rd_hold: got %0d, want 5", rdW); end
        regwriteM = 1'b0;
        $display("test_main_only done");
    endtask

    task automatic test_long_latency();
        lu_valid = 1'b1; lu_rd = 5'd10; lu_data = 32'h2A;
        step();
        lu_valid = 1'b0;
`ifdef WB_BYPASS_EN
        n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'd10 || resultW !== 32'h2A) begin
            n_fail++; $display("FAIL ll_bypass_write: got we=%b rd=%0d data=%h, want 1/10/2a", regwriteW, rdW, resultW); end
        n_checks++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL ll_bypass_pend: got %h, want 0", pend_mask); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ll_bypass_count: got %0d, want 0", fifo_count); end
        step();
        n_checks++; if (regwriteW !== 1'b0) begin n_fail++; $display("FAIL ll_bypass_idle: got %b, want 0", regwriteW); end
`else
        n_checks++; if (pend_mask !== 32'h400) begin n_fail++; $display("FAIL ll_pend_set: got %h, want 00000400", pend_mask); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL ll_count1: got %0d, want 1", fifo_count); end
        n_checks++; if (regwriteW !== 1'b0) begin n_fail++; $display("FAIL ll_no_fallthrough: got %b, want 0", regwriteW); end
        step();
        n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'd10 || resultW !== 32'h2A) begin
            n_fail++; $display("FAIL ll_write: got we=%b rd=%0d data=%h, want 1/10/2a", regwriteW, rdW, resultW); end
        n_checks++; if (pend_mask !== 32'h0) begin n_fail++; $display("FAIL ll_pend_clear: got %h, want 0", pend_mask); end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL ll_count0: got %0d, want 0", fifo_count); end
`endif
        $display("test_long_latency done");
    endtask

    task automatic test_fill_order();
        regwriteM = 1'b1; rdM = 5'd9; resultM = 32'h99;
        for (int i = 1; i <= 4; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(i); lu_data = 32'h100 + 32'(i);
            step();
        end
        lu_valid = 1'b0;
        n_checks++; if (fifo_count !== 3'd4) begin n_fail++; $display("FAIL fill_count: got %0d, want 4", fifo_count); end
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b, want 0", lu_ready); end
        n_checks++; if (pend_mask !== 32'h1E) begin n_fail++; $display("FAIL fill_pend: got %h, want 0000001e", pend_mask); end
        n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'd9 || resultW !== 32'h99) begin
            n_fail++; $display("FAIL fill_main: got we=%b rd=%0d data=%h, want 1/9/99", regwriteW, rdW, resultW); end
        regwriteM = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'(i) || resultW !== 32'h100 + 32'(i)) begin
                n_fail++; $display("FAIL drain_%0d: got we=%b rd=%0d data=%h, want 1/%0d/%h",
                                   i, regwriteW, rdW, resultW, i, 32'h100 + 32'(i)); end
            if (i == 1) begin
                n_checks++; if (lu_ready !== 1'b1) begin n_fail++; $display("FAIL drain_ready: got %b, want 1", lu_ready); end
            end
        end
        n_checks++; if (fifo_count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d, want 0", fifo_count); end
        $display("test_fill_order done");
    endtask

    task automatic test_starvation();
        regwriteM = 1'b1; rdM = 5'd9; resultM = 32'h99;
        lu_valid = 1'b1; lu_rd = 5'd12; lu_data = 32'h55;
        step();
        lu_valid = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            step();
            n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL starve_early_%0d: got %b, want 0", k, hold_req); end
        end
        step();
        n_checks++; if (hold_req !== 1'b1) begin n_fail++; $display("FAIL starve_rise: got %b, want 1", hold_req); end
        step();
        n_checks++; if (hold_req !== 1'b1) begin n_fail++; $display("FAIL starve_stay: got %b, want 1", hold_req); end
        n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'd9) begin
            n_fail++; $display("FAIL starve_main_wins: got we=%b rd=%0d, want 1/9", regwriteW, rdW); end
        n_checks++; if (fifo_count !== 3'd1) begin n_fail++; $display("FAIL starve_count: got %0d, want 1", fifo_count); end
        regwriteM = 1'b0;
        step();
        n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'd12 || resultW !== 32'h55) begin
            n_fail++; $display("FAIL starve_pop: got we=%b rd=%0d data=%h, want 1/12/55", regwriteW, rdW, resultW); end
        step();
        n_checks++; if (hold_req !== 1'b0) begin n_fail++; $display("FAIL starve_release: got %b, want 0", hold_req); end
        $display("test_starvation done");
    endtask

    task automatic test_rd0_and_reset();
        regwriteM = 1'b1; rdM = 5'd9; resultM = 32'h99;
        lu_valid = 1'b1; lu_rd = 5'd0; lu_data = 32'hAA;
        step();
        lu_rd = 5'd7; lu_data = 32'h77;
        step();
        lu_valid = 1'b0;
        n_checks++; if (pend_mask !== 32'h81) begin n_fail++; $display("FAIL rd0_pend: got %h, want 00000081", pend_mask); end
        regwriteM = 1'b0;
        step();
        n_checks++; if (regwriteW !== 1'b0) begin n_fail++; $display("FAIL rd0_discard: got %b, want 0", regwriteW); end
        n_checks++; if (fifo_count !== 3'd1 || pend_mask !== 32'h80) begin
            n_fail++; $display("FAIL rd0_popped: got count=%0d pend=%h, want 1/00000080", fifo_count, pend_mask); end
        step();
        n_checks++; if (regwriteW !== 1'b1 || rdW !== 5'd7 || resultW !== 32'h77) begin
            n_fail++; $display("FAIL rd7_write: got we=%b rd=%0d data=%h, want 1/7/77", regwriteW, rdW, resultW); end

        // Queue three entries behind a busy main pipeline, then reset.
        regwriteM = 1'b1; rdM = 5'd9; resultM = 32'h99;
        for (int i = 1; i <= 3; i++) begin
            lu_valid = 1'b1; lu_rd = 5'(i + 20); lu_data = 32'(i);
            step();
        end
        n_checks++; if (fifo_count !== 3'd3) begin n_fail++; $display("FAIL mid_count3: got %0d, want 3", fifo_count); end
        rst = 1'b1; regwriteM = 1'b0; lu_rd = 5'd30;
        #0;
        n_checks++; if (lu_ready !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got %b, want 0", lu_ready); end
        step();
        n_checks++; if (fifo_count !== 3'd0 || pend_mask !== 32'h0) begin
            n_fail++; $display("FAIL mid_rst_flush: got count=%0d pend=%h, want 0/0", fifo_count, pend_mask); end
        n_checks++; if (regwriteW !== 1'b0 || hold_req !== 1'b0) begin
            n_fail++; $display("FAIL mid_rst_outs: got we=%b hold=%b, want 0/0", regwriteW, hold_req); end
        rst = 1'b0; lu_valid = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_checks++; if (regwriteW !== 1'b0 || fifo_count !== 3'd0) begin
                n_fail++; $display("FAIL post_rst_%0d: got we=%b count=%0d, want 0/0", k, regwriteW, fifo_count); end
        end
        $display("test_rd0_and_reset done");
    endtask

    initial begin
        test_reset();
        test_main_only();
        test_long_latency();
        test_fill_order();
        test_starvation();
        test_rd0_and_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
